// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback slice: word widths, status-op
// encoding, status bit positions and the writeback control states.
package alu_pkg;

    localparam int DATA_W = 20;
    localparam int HALF_W = DATA_W / 2;
    localparam int ADDR_W = 4;

    // Encoding of the per-op status register action
    typedef enum logic [1:0] {
        SR_ALU  = 2'b00,
        SR_LSR  = 2'b01,
        SR_XSR  = 2'b10,
        SR_NONE = 2'b11
    } sr_op_t;

    // Bit positions inside the {T,C,S,Z} status register
    localparam int STAT_Z = 0;
    localparam int STAT_S = 1;
    localparam int STAT_C = 2;
    localparam int STAT_T = 3;

    // Writeback control states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        TRAP  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result input handshake and register-file write port, bundled.
// The slave modport is the writeback stage; master is the ALU/regfile side.
interface alu_writeback_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic              in_sign;
    logic              in_carry;
    logic              in_mode;
    logic              in_wr_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [1:0]        in_sr_op;
    logic              in_trap;

    logic              rf_we;
    logic              rf_ready;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output in_valid, in_result, in_zero, in_sign, in_carry, in_mode,
               in_wr_en, in_rd_addr, in_sr_op, in_trap, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_sign, in_carry, in_mode,
               in_wr_en, in_rd_addr, in_sr_op, in_trap, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/alu_writeback_skid_buf.sv
// Two-entry FIFO between the writeback stage and the register file.
// The head entry is presented straight from storage, so a pushed item is
// visible on the pop side one cycle after the push and stays stable while
// the consumer is not ready.
module wb_skid_buf #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign push_ready = (cnt != FULL_CNT);
    assign pop_valid  = (cnt != 2'd0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];
    assign count      = cnt;

    // Storage, pointers and occupancy; reset clears contents so the pop side reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: owns the {T,C,S,Z} status register, applies the
// LSR/XSR status ops, masks half-word results and feeds register-file
// writes through a 2-entry skid buffer. A Trap op halts intake until the
// buffer has drained and trap_clear is pulsed.
// Optional build macro ALU_WB_PERF_CNT_EN adds retired_cnt and stall_cnt.
module alu_writeback #(
    parameter int DATA_W    = alu_pkg::DATA_W,
    parameter int ADDR_W    = alu_pkg::ADDR_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_writeback_if.slave bus,
    output logic [3:0]  status,
    output logic        trap_active,
    input  logic        trap_clear
`ifdef ALU_WB_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    import alu_pkg::*;

    localparam int HALF  = DATA_W / 2;
    localparam int PKT_W = ADDR_W + DATA_W;

    wb_state_t         state;
    wb_state_t         state_next;
    sr_op_t            sr_op;
    logic              started;
    logic              accept;
    logic              push;
    logic              pop;
    logic              buf_ready;
    logic [1:0]        buf_count;
    logic [1:0]        count_next;
    logic [DATA_W-1:0] wdata_in;
    logic [PKT_W-1:0]  push_pkt;
    logic [PKT_W-1:0]  head_pkt;
    logic [3:0]        status_next;

    // Holds intake closed until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    assign bus.in_ready = started && buf_ready && (state != TRAP);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && bus.in_wr_en && !bus.in_trap;
    assign pop          = bus.rf_we && bus.rf_ready;
    assign sr_op        = sr_op_t'(bus.in_sr_op);
    assign trap_active  = (state == TRAP);
    assign count_next   = buf_count + {1'b0, push} - {1'b0, pop};

    assign wdata_in = bus.in_mode ? bus.in_result
                                  : {{(DATA_W-HALF){1'b0}}, bus.in_result[HALF-1:0]};
    assign push_pkt = {bus.in_rd_addr, wdata_in};

    wb_skid_buf #(
        .W     (PKT_W),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push),
        .push_ready (buf_ready),
        .push_data  (push_pkt),
        .pop_valid  (bus.rf_we),
        .pop_ready  (bus.rf_ready),
        .pop_data   (head_pkt),
        .count      (buf_count)
    );

    assign bus.rf_waddr = head_pkt[PKT_W-1:DATA_W];
    assign bus.rf_wdata = head_pkt[DATA_W-1:0];

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: stall tracks buffer occupancy, a trap overrides everything
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (count_next == 2'd2) state_next = STALL;
            STALL:   if (count_next <= 2'd1) state_next = RUN;
            TRAP:    if (trap_clear && (buf_count == 2'd0)) state_next = RUN;
            default: state_next = RUN;
        endcase
        if (accept && bus.in_trap) begin
            state_next = TRAP;
        end
    end

    // Status update from the accepted op, or T cleared when leaving TRAP
    always_comb begin
        status_next = status;
        if (accept) begin
            if (bus.in_trap) begin
                status_next[STAT_T] = 1'b1;
            end else begin
                case (sr_op)
                    SR_ALU: begin
                        status_next[STAT_Z] = bus.in_zero;
                        status_next[STAT_S] = bus.in_sign;
                        status_next[STAT_C] = bus.in_carry;
                    end
                    SR_LSR:  status_next = bus.in_result[3:0];
                    SR_XSR:  status_next = status ^ bus.in_result[3:0];
                    default: status_next = status;
                endcase
            end
        end else if ((state == TRAP) && (state_next == RUN)) begin
            status_next[STAT_T] = 1'b0;
        end
    end

    // Architectural status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 4'b0000;
        end else begin
            status <= status_next;
        end
    end

`ifdef ALU_WB_PERF_CNT_EN
    // Retired-op and input-stall event counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            if (accept && !bus.in_trap) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (bus.in_valid && !bus.in_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: reset, full/half-word writes,
// LSR/XSR status ops, register-file backpressure, trap handling and
// asynchronous reset with a full buffer.
module tb_alu_writeback;

    logic clk;
    logic rst_n;
    logic trap_clear;
    logic [3:0] status;
    logic trap_active;
`ifdef ALU_WB_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    alu_writeback_if #(.DATA_W(20), .ADDR_W(4)) bus ();

    alu_writeback #(
        .DATA_W    (20),
        .ADDR_W    (4),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .status      (status),
        .trap_active (trap_active),
        .trap_clear  (trap_clear)
`ifdef ALU_WB_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid   = 1'b0;
        bus.in_result  = '0;
        bus.in_zero    = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_carry   = 1'b0;
        bus.in_mode    = 1'b1;
        bus.in_wr_en   = 1'b0;
        bus.in_rd_addr = '0;
        bus.in_sr_op   = 2'b11;
        bus.in_trap    = 1'b0;
    endtask

    task automatic drive_op(input logic [19:0] res, input logic mode, input logic wr_en,
                            input logic [3:0] rd, input logic [1:0] op,
                            input logic z, input logic s, input logic c, input logic trap);
        bus.in_valid   = 1'b1;
        bus.in_result  = res;
        bus.in_mode    = mode;
        bus.in_wr_en   = wr_en;
        bus.in_rd_addr = rd;
        bus.in_sr_op   = op;
        bus.in_zero    = z;
        bus.in_sign    = s;
        bus.in_carry   = c;
        bus.in_trap    = trap;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        trap_clear    = 1'b0;
        bus.rf_ready  = 1'b0;
        drive_idle();
        #2;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rf_we: got %0b want 0", bus.rf_we); end
        n_checks++;
        if (status !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_status: got %b want 0000", status); end
        n_checks++;
        if (bus.rf_waddr !== 4'h0 || bus.rf_wdata !== 20'h0) begin
            n_fail++; $display("[TB] FAIL rst_rf_bus: got addr %h data %h want 0/0", bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (trap_active !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_trap: got %0b want 0", trap_active); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rel_in_ready_early: got %0b want 0", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rel_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_full_word();
        bus.rf_ready = 1'b1;
        drive_op(20'hABCDE, 1'b1, 1'b1, 4'd3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_idle();
        n_checks++;
        if (bus.rf_we !== 1'b1) begin n_fail++; $display("[TB] FAIL fw_we: got %0b want 1", bus.rf_we); end
        n_checks++;
        if (bus.rf_waddr !== 4'd3) begin n_fail++; $display("[TB] FAIL fw_addr: got %0d want 3", bus.rf_waddr); end
        n_checks++;
        if (bus.rf_wdata !== 20'hABCDE) begin n_fail++; $display("[TB] FAIL fw_data: got %h want abcde", bus.rf_wdata); end
        n_checks++;
        if (status !== 4'b0110) begin n_fail++; $display("[TB] FAIL fw_status: got %b want 0110", status); end
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL fw_drain: got %0b want 0", bus.rf_we); end
    endtask

    task automatic test_half_word();
        drive_op(20'hFFFFF, 1'b0, 1'b1, 4'd5, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive_idle();
        n_checks++;
        if (bus.rf_wdata !== 20'h003FF) begin n_fail++; $display("[TB] FAIL hw_data: got %h want 003ff", bus.rf_wdata); end
        n_checks++;
        if (bus.rf_waddr !== 4'd5) begin n_fail++; $display("[TB] FAIL hw_addr: got %0d want 5", bus.rf_waddr); end
        n_checks++;
        if (status !== 4'b0110) begin n_fail++; $display("[TB] FAIL hw_status_hold: got %b want 0110", status); end
        tick();
    endtask

    task automatic test_lsr_xsr();
        drive_op(20'h00005, 1'b1, 1'b0, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        n_checks++;
        if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL lsr_status: got %b want 0101", status); end
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL lsr_no_write: got %0b want 0", bus.rf_we); end
        drive_op(20'h00003, 1'b1, 1'b0, 4'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        n_checks++;
        if (status !== 4'b0110) begin n_fail++; $display("[TB] FAIL xsr_status: got %b want 0110", status); end
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL xsr_no_write: got %0b want 0", bus.rf_we); end
    endtask

    task automatic test_backpressure();
        bus.rf_ready = 1'b0;
        drive_op(20'h11111, 1'b1, 1'b1, 4'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_first: got %0b want 1", bus.in_ready); end
        tick();
        drive_op(20'h22222, 1'b1, 1'b1, 4'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_second: got %0b want 1", bus.in_ready); end
        tick();
        drive_op(20'h33333, 1'b1, 1'b1, 4'd3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %0b want 0", bus.in_ready); end
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.rf_wdata !== 20'h11111 || bus.rf_waddr !== 4'd1) begin
            n_fail++; $display("[TB] FAIL bp_hold: got ready %0b addr %0d data %h want 0/1/11111", bus.in_ready, bus.rf_waddr, bus.rf_wdata);
        end
        bus.rf_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.rf_wdata !== 20'h22222 || bus.rf_waddr !== 4'd2) begin
            n_fail++; $display("[TB] FAIL bp_second_out: got addr %0d data %h want 2/22222", bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_reopen: got %0b want 1", bus.in_ready); end
        tick();
        drive_idle();
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 20'h33333 || bus.rf_waddr !== 4'd3) begin
            n_fail++; $display("[TB] FAIL bp_third_out: got we %0b addr %0d data %h want 1/3/33333", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_empty: got %0b want 0", bus.rf_we); end
    endtask

    task automatic test_trap();
        bus.rf_ready = 1'b0;
        drive_op(20'h77777, 1'b1, 1'b1, 4'd7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_op(20'h12345, 1'b1, 1'b1, 4'd9, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive_idle();
        n_checks++;
        if (trap_active !== 1'b1) begin n_fail++; $display("[TB] FAIL trap_active: got %0b want 1", trap_active); end
        n_checks++;
        if (status !== 4'b1110) begin n_fail++; $display("[TB] FAIL trap_status: got %b want 1110", status); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL trap_in_ready: got %0b want 0", bus.in_ready); end
        trap_clear = 1'b1;
        tick();
        trap_clear = 1'b0;
        n_checks++;
        if (trap_active !== 1'b1) begin n_fail++; $display("[TB] FAIL trap_clear_early: got %0b want 1", trap_active); end
        bus.rf_ready = 1'b1;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd7) begin
            n_fail++; $display("[TB] FAIL trap_drain_head: got we %0b addr %0d want 1/7", bus.rf_we, bus.rf_waddr);
        end
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL trap_no_write: got %0b want 0", bus.rf_we); end
        n_checks++;
        if (trap_active !== 1'b1) begin n_fail++; $display("[TB] FAIL trap_hold: got %0b want 1", trap_active); end
        trap_clear = 1'b1;
        tick();
        trap_clear = 1'b0;
        n_checks++;
        if (trap_active !== 1'b0) begin n_fail++; $display("[TB] FAIL trap_exit: got %0b want 0", trap_active); end
        n_checks++;
        if (status !== 4'b0110) begin n_fail++; $display("[TB] FAIL trap_t_clear: got %b want 0110", status); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL trap_resume: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_async_reset();
        bus.rf_ready = 1'b0;
        drive_op(20'hAAAAA, 1'b1, 1'b1, 4'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_op(20'hBBBBB, 1'b1, 1'b1, 4'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_idle();
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ar_full: got we %0b ready %0b want 1/0", bus.rf_we, bus.in_ready);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_rf_we: got %0b want 0", bus.rf_we); end
        n_checks++;
        if (status !== 4'b0000) begin n_fail++; $display("[TB] FAIL ar_status: got %b want 0000", status); end
        n_checks++;
        if (bus.rf_wdata !== 20'h0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ar_bus: got data %h ready %0b want 0/0", bus.rf_wdata, bus.in_ready);
        end
        #2;
        rst_n = 1'b1;
        bus.rf_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ar_after: got we %0b ready %0b want 0/1", bus.rf_we, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_empty: got %0b want 0", bus.rf_we); end
    endtask

    // Scenario sequence and summary
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_word();
        test_half_word();
        test_lsr_xsr();
        test_backpressure();
        test_trap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU operation circuits.
- Accepts one ALU result per handshake, together with its zero/sign/carry flags and the full-/half-word mode bit.
- Owns the architectural status register (Z, S, C, T) and implements the Load Status Register and XOR Status Register program-flow ops.
- Drives register-file write ports through a 2-entry skid buffer, so register-file backpressure never drops a result.

Parameters:
- DATA_W, 20, ALU word width; half word is DATA_W/2.
- ADDR_W, 4, register-file address width.
- BUF_DEPTH, 2, skid-buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept.
- in_result  in  DATA_W  ALU output word.
- in_zero  in  1  ALU zero flag.
- in_sign  in  1  ALU sign flag.
- in_carry  in  1  ALU carry flag.
- in_mode  in  1  1 = full word, 0 = half word.
- in_wr_en  in  1  result targets the register file.
- in_rd_addr  in  ADDR_W  destination register.
- in_sr_op  in  2  00 = flags from ALU, 01 = LSR, 10 = XSR, 11 = no status change.
- in_trap  in  1  op is the Trap instruction.
- rf_we  out  1  register-file write valid.
- rf_ready  in  1  register file accepts the write.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- status  out  4  {T,C,S,Z} status register.
- trap_active  out  1  stage is halted in TRAP.
- trap_clear  in  1  one-cycle pulse that leaves TRAP.

Behaviour:
- Reset (async, while rst_n = 0):
  - status = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - Buffer empty, FSM = RUN, in_ready = 0 during reset.
  - in_ready = 1 from the first clk edge after release.
- Accept: transfer occurs when in_valid && in_ready at a rising clk edge.
- Half-word mode:
  - Write data = {10'b0, in_result[9:0]}.
  - The upper half is forced to 0 regardless of input.
- Write path (only for accepted items with in_wr_en = 1):
  - Item enters the buffer.
  - rf_we/rf_waddr/rf_wdata present the buffer head 1 cycle after accept (latency 1).
  - Head pops on rf_we && rf_ready.
- Status update:
  - Takes effect in the cycle after accept, independent of the write path and of rf_ready.
  - in_sr_op 00: Z, S, C <= in_zero, in_sign, in_carry; T unchanged.
  - 01 (LSR): status <= in_result[3:0].
  - 10 (XSR): status <= status ^ in_result[3:0].
  - 11: no change.
- Buffer:
  - in_ready = 0 when the buffer is full (2 entries) or FSM = TRAP.
  - Simultaneous push and pop on a full buffer is not permitted; in_ready is already low.
  - Push and pop on a 1-entry buffer keeps the count at 1.
  - Order is strictly FIFO.
- FSM:
  - RUN -> STALL when the buffer is full.
  - STALL -> RUN when a pop leaves at most 1 entry.
  - Any state -> TRAP on accept with in_trap = 1. The trap op itself writes nothing; status.T <= 1.
  - TRAP: in_ready = 0; already-buffered writes still drain; trap_active = 1.
  - TRAP -> RUN on trap_clear, but only once the buffer is empty.
  - TRAP -> RUN also clears T.
  - trap_clear outside TRAP is ignored.
- Reset mid-operation: buffered writes are discarded with no partial write; rf_we drops immediately (async).
- rf_wdata/rf_waddr hold stable while rf_we && !rf_ready.

Optional Feature:
- Macro: ALU_WB_PERF_CNT_EN.
- When defined, adds two extra outputs:
  - retired_cnt[31:0]: +1 per accepted non-trap item.
  - stall_cnt[31:0]: +1 per cycle with in_valid && !in_ready.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined: no ports and no counter logic; all other behaviour identical.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, HALF_W.
  - sr_op enum (SR_ALU, SR_LSR, SR_XSR, SR_NONE).
  - Status bit indices (Z = 0, S = 1, C = 2, T = 3).
  - wb_state enum (RUN, STALL, TRAP).
- One sub-module, wb_skid_buf: 2-entry FIFO carrying {addr, data} with valid/ready both sides.

Test Plan:
1. Full-word write:
   - Stimulus: in_result = 20'hABCDE, mode = 1, rd = 3, sr_op = 00, Z/S/C = 0/1/1, rf_ready = 1.
   - Required: next cycle rf_we = 1, waddr = 3, wdata = ABCDE; status = 4'b0110.
2. Half-word masking:
   - Stimulus: in_result = 20'hFFFFF, mode = 0.
   - Required: rf_wdata = 20'h003FF.
3. LSR then XSR:
   - Stimulus: LSR with result = 4'b0101, then XSR with result = 4'b0011.
   - Required: status = 0101, then 0110; no register write when wr_en = 0.
4. Backpressure:
   - Stimulus: rf_ready = 0, three back-to-back valid writes.
   - Required: first two accepted, in_ready = 0 on the third.
   - Then raise rf_ready: writes drain in order, third is accepted and lands after them.
5. Trap:
   - Stimulus: accept a trap op with 1 write buffered and rf_ready = 0.
   - Required: trap_active = 1, T = 1, in_ready = 0.
   - trap_clear while the buffer is non-empty is ignored.
   - After the drain, trap_clear gives RUN with T = 0.
6. Async reset:
   - Stimulus: assert rst_n = 0 mid-clock with 2 entries buffered.
   - Required: rf_we = 0 and status = 0 immediately; buffer empty after release.
